alignment_collector: RTL and testbench

//  Downstream consumer of the traceback unit. Drives start_traceback and captures the
//  (R,Q) base-pair stream, which traceback emits last-column-first. Stores the pairs in a

---
 rtl/alignment_collector.sv | 156 +++++++++++++++
 tb/tb_alignment_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alignment_collector.sv
// alignment_collector: drives traceback, captures its reverse-order (R,Q) pair
// stream into a LIFO and replays it forward-order on a valid/ready stream,
// while counting matches, mismatches and gaps of the captured alignment.
module alignment_collector #(
   parameter int L     = 8,
   parameter int DEPTH = 2 * L,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          start_tb,
   input  logic [2:0]    tb_r,
   input  logic [2:0]    tb_q,
   input  logic          tb_finish,
   output logic [2:0]    aln_r,
   output logic [2:0]    aln_q,
   output logic          aln_valid,
   input  logic          aln_ready,
   output logic          aln_last,
   output logic          done,
   output logic [CW-1:0] aln_len,
   output logic [CW-1:0] match_cnt,
   output logic [CW-1:0] mism_cnt,
   output logic [CW-1:0] gap_cnt,
   output logic          overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] SYM_IDLE = 3'b111;
   localparam logic [2:0] SYM_GAP  = 3'b100;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t        state, state_nxt;

   logic [5:0]    mem [DEPTH];
   logic [CW-1:0] ptr;

   logic          accept_start;
   logic          push_try;
   logic          push_ok;
   logic          full;
   logic          fin;
   logic          head_load;
   logic          drain_end;
   logic          pair_gap;
   logic          pair_match;
   logic [CW-1:0] len_after;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;

   // Symbol classification and LIFO addressing used by the control logic
   always_comb begin
      full       = (ptr == CW'(DEPTH));
      pair_gap   = (tb_r == SYM_GAP) || (tb_q == SYM_GAP);
      pair_match = (tb_r == tb_q);
      wr_idx     = AW'(ptr);
      top_idx    = AW'(ptr - CW'(1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a finish that leaves the LIFO empty skips DRAIN
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COLLECT;
         COLLECT: if (tb_finish) state_nxt = (len_after == '0) ? IDLE : DRAIN;
         DRAIN:   if (drain_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-state control strobes
   always_comb begin
      busy         = (state != IDLE);
      accept_start = (state == IDLE) && start;
      push_try     = (state == COLLECT) && (tb_r != SYM_IDLE);
      push_ok      = push_try && !full;
      len_after    = aln_len + {{(CW-1){1'b0}}, push_ok};
      fin          = (state == COLLECT) && tb_finish;
      // The output register is refilled whenever it is empty or being consumed
      head_load    = (state == DRAIN) && (!aln_valid || aln_ready) && (ptr != '0);
      drain_end    = (state == DRAIN) && aln_valid && aln_ready && aln_last;
   end

   // LIFO storage; contents need no reset since the pointer gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_idx] <= {tb_r, tb_q};
   end

   // Traceback handshake, LIFO pointer, counters, overflow and done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_tb  <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         ptr       <= '0;
         aln_len   <= '0;
         match_cnt <= '0;
         mism_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         done <= 1'b0;
         if (accept_start) begin
            start_tb  <= 1'b1;
            overflow  <= 1'b0;
            ptr       <= '0;
            aln_len   <= '0;
            match_cnt <= '0;
            mism_cnt  <= '0;
            gap_cnt   <= '0;
         end
         if (push_try && full) overflow <= 1'b1;
         if (push_ok) begin
            ptr     <= ptr + CW'(1);
            aln_len <= aln_len + CW'(1);
            if (pair_gap)        gap_cnt   <= gap_cnt + CW'(1);
            else if (pair_match) match_cnt <= match_cnt + CW'(1);
            else                 mism_cnt  <= mism_cnt + CW'(1);
         end
         if (fin) begin
            start_tb <= 1'b0;
            if (len_after == '0) done <= 1'b1;
         end
         if (head_load) ptr <= ptr - CW'(1);
         if (drain_end) done <= 1'b1;
      end
   end

   // Registered forward-order output stage, popping the LIFO top
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aln_r     <= SYM_IDLE;
         aln_q     <= SYM_IDLE;
         aln_valid <= 1'b0;
         aln_last  <= 1'b0;
      end else if (head_load) begin
         aln_r     <= mem[top_idx][5:3];
         aln_q     <= mem[top_idx][2:0];
         aln_valid <= 1'b1;
         aln_last  <= (ptr == CW'(1));
      end else if (drain_end) begin
         aln_valid <= 1'b0;
         aln_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alignment_collector.sv
// tb_alignment_collector: directed and randomized alignments checked against a
// queue-based reference of the collector's capture/replay rules.
module tb_alignment_collector;

   localparam int L     = 8;
   localparam int DEPTH = 2 * L;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          start_tb;
   logic [2:0]    tb_r;
   logic [2:0]    tb_q;
   logic          tb_finish;
   logic [2:0]    aln_r;
   logic [2:0]    aln_q;
   logic          aln_valid;
   logic          aln_ready;
   logic          aln_last;
   logic          done;
   logic [CW-1:0] aln_len;
   logic [CW-1:0] match_cnt;
   logic [CW-1:0] mism_cnt;
   logic [CW-1:0] gap_cnt;
   logic          overflow;

   alignment_collector #(.L(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .start_tb  (start_tb),
      .tb_r      (tb_r),
      .tb_q      (tb_q),
      .tb_finish (tb_finish),
      .aln_r     (aln_r),
      .aln_q     (aln_q),
      .aln_valid (aln_valid),
      .aln_ready (aln_ready),
      .aln_last  (aln_last),
      .done      (done),
      .aln_len   (aln_len),
      .match_cnt (match_cnt),
      .mism_cnt  (mism_cnt),
      .gap_cnt   (gap_cnt),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state for the current alignment
   logic [5:0] exp_q[$];
   int e_len, e_match, e_mism, e_gap;
   bit e_ov;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_len"},   aln_len,   e_len);
      chk({tag, "_match"}, match_cnt, e_match);
      chk({tag, "_mism"},  mism_cnt,  e_mism);
      chk({tag, "_gap"},   gap_cnt,   e_gap);
      chk({tag, "_ovf"},   overflow,  e_ov);
   endtask

   // random pair stream in traceback emission order, optional idle bubbles
   task automatic gen(input int n, input bit bubbles, output logic [5:0] s[$]);
      logic [2:0] syms [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      s.delete();
      for (int i = 0; i < n; i++) begin
         if (bubbles && i > 0 && $urandom_range(0, 4) == 0) s.push_back(6'o77);
         s.push_back({syms[$urandom_range(0, 6)], syms[$urandom_range(0, 6)]});
      end
   endtask

   // start an alignment, play traceback (leading 111, pairs, finish on last)
   task automatic collect(input logic [5:0] s[$]);
      exp_q.delete();
      e_len = 0; e_match = 0; e_mism = 0; e_gap = 0; e_ov = 0;
      foreach (s[i]) begin
         logic [2:0] r, q;
         r = s[i][5:3];
         q = s[i][2:0];
         if (r == 3'd7) continue;
         if (exp_q.size() == DEPTH) begin
            e_ov = 1;
            continue;
         end
         exp_q.push_back(s[i]);
         e_len++;
         if (r == 3'd4 || q == 3'd4) e_gap++;
         else if (r == q)           e_match++;
         else                       e_mism++;
      end
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_tb_rise", start_tb, 1);
      chk("busy_collect", busy, 1);
      chk("len_cleared", aln_len, 0);
      tb_r = 3'd7; tb_q = 3'd7; tb_finish = 1'b0;
      step();
      foreach (s[i]) begin
         tb_r = s[i][5:3];
         tb_q = s[i][2:0];
         tb_finish = (i == s.size() - 1);
         step();
      end
      chk("start_tb_fall", start_tb, 0);
      chk("busy_after_fin", busy, e_len != 0);
      chk_counts("collect");
      // traceback's trailing output cycle must be ignored
      tb_r = 3'd2; tb_q = 3'd2; tb_finish = 1'b1;
      step();
      tb_r = 3'd7; tb_q = 3'd7; tb_finish = 1'b0;
   endtask

   // drain with mode 0: always ready, 1: ready 1,0,0 repeating, 2: random
   task automatic drain(input int mode);
      int k = 0;
      int n = exp_q.size();
      bit got_done = 0;
      bit rdy;
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         aln_ready = rdy;
         chk("done_early", done, 0);
         if (k < n) begin
            chk("out_valid", aln_valid, 1);
            chk("out_r", aln_r, exp_q[n-1-k][5:3]);
            chk("out_q", aln_q, exp_q[n-1-k][2:0]);
            chk("out_last", aln_last, k == n - 1);
            if (aln_valid && rdy) k++;
         end else begin
            chk("extra_valid", aln_valid, 0);
         end
         step();
         if (done === 1'b1) got_done = 1;
      end
      aln_ready = 1'b0;
      chk("done_seen", got_done, 1);
      chk("pairs_out", k, n);
      chk("busy_idle", busy, 0);
      chk("valid_low", aln_valid, 0);
      step();
      chk("done_pulse", done, 0);
      chk_counts("hold");
   endtask

   initial begin
      logic [5:0] s[$];

      // reset with start held high
      rst_n = 1'b0; start = 1'b1; tb_r = 3'd7; tb_q = 3'd7; tb_finish = 1'b0; aln_ready = 1'b0;
      step();
      step();
      chk("rst_start_tb", start_tb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", aln_valid, 0);
      chk("rst_r", aln_r, 3'b111);
      chk("rst_q", aln_q, 3'b111);
      chk("rst_done", done, 0);
      e_len = 0; e_match = 0; e_mism = 0; e_gap = 0; e_ov = 0;
      chk_counts("rst");
      rst_n = 1'b1; start = 1'b0;
      step();

      // gapless 8-pair all-match alignment
      s = '{6'o00, 6'o11, 6'o22, 6'o33, 6'o55, 6'o66, 6'o00, 6'o11};
      collect(s);
      chk("gapless_match", match_cnt, 8);
      drain(0);

      // gaps with 1,0,0 backpressure
      s = '{6'o34, 6'o42, 6'o11, 6'o25};
      collect(s);
      chk("gaps_gap", gap_cnt, 2);
      drain(1);

      // single-pair alignment, then restart two cycles after done
      s = '{6'o66};
      collect(s);
      drain(0);
      gen(6, 1'b1, s);
      collect(s);
      drain(2);

      // overflow: 17 valid pairs into 16 entries
      gen(17, 1'b0, s);
      collect(s);
      chk("ovf_flag", overflow, 1);
      chk("ovf_len", aln_len, 16);
      drain(2);

      // randomized alignments with bubbles and random backpressure
      for (int t = 0; t < 6; t++) begin
         gen($urandom_range(1, 16), 1'b1, s);
         collect(s);
         drain(2);
      end

      // reset in the middle of DRAIN
      gen(5, 1'b0, s);
      collect(s);
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_valid", aln_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_start_tb", start_tb, 0);
      e_len = 0; e_match = 0; e_mism = 0; e_gap = 0; e_ov = 0;
      chk_counts("mid_rst");
      step();

      // recovery after reset
      gen(10, 1'b1, s);
      collect(s);
      drain(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
